// File: rtl/sar_defs.sv
// Shared definitions for the successive-approximation search controller.
// Holds state encodings and the comparator-code validity check.
package sar_defs;

  typedef enum logic [1:0] {
    SAR_IDLE = 2'd0,
    SAR_TEST = 2'd1,
    SAR_DONE = 2'd2
  } sar_state_t;

  // A well-formed comparator response has exactly this many lines high.
  localparam int SAR_CODE_HOT = 1;

  function automatic logic code_ok(
    input logic e,
    input logic g,
    input logic l
  );
    return ($countones({e, g, l}) == SAR_CODE_HOT);
  endfunction

endpackage

// File: rtl/sar_step.sv
// One successive-approximation bit decision: resolve trial[idx] from the
// comparator and raise the next lower trial bit.
module sar_step #(
  parameter int WIDTH = 4,
  parameter int IW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] trial,
  input  logic [IW-1:0]    idx,
  input  logic             greater,
  output logic [WIDTH-1:0] nxt,
  output logic             last
);

  assign last = (idx == '0);

  always_comb begin
    nxt = trial;
    if (greater)
      nxt[idx] = 1'b0;
    if (!last)
      nxt[idx - 1'b1] = 1'b1;
  end

endmodule

// File: rtl/sar_search.sv
// Successive-approximation search controller driving an external comparator.
// Define SAR_EARLY_EXIT_EN to end a search as soon as the comparator reports equal.
module sar_search
  import sar_defs::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             equal,
  input  logic             greater,
  input  logic             lesser,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int IW = $clog2(WIDTH);

  sar_state_t       state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] nxt;
  logic             last;
  logic             ok;
  logic             hit;

  assign ok = code_ok(equal, greater, lesser);

`ifdef SAR_EARLY_EXIT_EN
  assign hit = ok & equal;
`else
  assign hit = 1'b0;
`endif

  sar_step #(
    .WIDTH (WIDTH),
    .IW    (IW)
  ) u_step (
    .trial   (trial),
    .idx     (idx),
    .greater (greater),
    .nxt     (nxt),
    .last    (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= SAR_IDLE;
      trial  <= '0;
      idx    <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      unique case (state)
        SAR_IDLE: begin
          done <= 1'b0;
          if (start) begin
            trial <= WIDTH'(1) << (WIDTH - 1);
            idx   <= IW'(WIDTH - 1);
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= SAR_TEST;
          end
        end
        SAR_TEST: begin
          if (!ok)
            err <= 1'b1;
          if (hit) begin
            result <= trial;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= SAR_DONE;
          end else if (last) begin
            trial  <= nxt;
            result <= nxt;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= SAR_DONE;
          end else begin
            trial <= nxt;
            idx   <= idx - 1'b1;
          end
        end
        SAR_DONE: begin
          done  <= 1'b0;
          state <= SAR_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= SAR_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search.sv
// Scoreboard bench for sar_search: comparator model, binary-search reference,
// monitor that checks every done pulse against queued expectations.
module tb_sar_search;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         equal, greater, lesser;
  logic [W-1:0] trial, result;
  logic         busy, done, err;

  sar_search #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .equal   (equal),
    .greater (greater),
    .lesser  (lesser),
    .trial   (trial),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .err     (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n;
    int tr[16];
    int res;
    int err;
  } exp_t;

  exp_t sb[$];
  int   obs[$];
  int   done_cyc[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ncyc  = 0;
  int ndone = 0;
  int unk   = 0;
  int fn    = 0;
  int rise_cyc = 0;
  bit prev_busy = 0;
  bit prev_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Comparator: true magnitude compare, optionally forced to an invalid code.
  always_comb begin
    equal   = (int'(trial) == unk);
    greater = (int'(trial) > unk);
    lesser  = (int'(trial) < unk);
    if (fn != 0 && ncyc == fn) begin
      equal   = 1'b0;
      greater = 1'b1;
      lesser  = 1'b1;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Reference: plain MSB-first binary search over an integer unknown.
  function automatic exp_t model(input int u, input int f);
    exp_t m;
    int acc, t;
    bit inv, gt;
    acc = 0;
    m.n = 0;
    m.err = 0;
    m.res = 0;
    for (int i = 0; i < 16; i++) m.tr[i] = 0;
    for (int b = W - 1; b >= 0; b--) begin
      t = acc | (1 << b);
      m.tr[m.n] = t;
      m.n++;
      inv = (m.n == f);
      if (inv) m.err = 1;
`ifdef SAR_EARLY_EXIT_EN
      if (!inv && t == u) begin
        m.res = t;
        return m;
      end
`endif
      gt = inv ? 1'b1 : (t > u);
      if (!gt) acc = t;
    end
    m.res = acc;
    return m;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      obs.delete();
      ncyc = 0;
      prev_busy = 0;
      prev_done = 0;
    end else begin
      if (busy && !prev_busy) rise_cyc = cyc;
      if (busy) begin
        obs.push_back(int'(trial));
        ncyc = obs.size();
      end
      if (done && prev_done) chk("done_width", 2, 1);
      if (done) begin
        ndone++;
        done_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", int'(result), e.res);
          chk("err", int'(err), e.err);
          chk("busy_at_done", int'(busy), 0);
          chk("latency", cyc - rise_cyc, e.n);
          chk("n_trials", obs.size(), e.n);
          for (int i = 0; i < e.n && i < obs.size(); i++)
            chk($sformatf("trial[%0d]", i), obs[i], e.tr[i]);
        end
        obs.delete();
        ncyc = 0;
      end
      prev_busy = busy;
      prev_done = done;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      step();
      if (!busy && !done) return;
    end
    chk("idle_timeout", 0, 1);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 60; i++) begin
      if (ndone >= target) return;
      step();
    end
    chk("done_timeout", ndone, target);
  endtask

  task automatic launch(input int u, input int f);
    wait_idle();
    unk = u;
    fn = f;
    sb.push_back(model(u, f));
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run(input int u, input int f);
    int base;
    base = ndone;
    launch(u, f);
    wait_done(base + 1);
  endtask

  task automatic wait_ncyc(input int n);
    for (int i = 0; i < 30; i++) begin
      if (ncyc == n) return;
      step();
    end
    chk("ncyc_timeout", ncyc, n);
  endtask

  initial begin
    int base;
    rst = 1'b1;
    repeat (2) step();
    chk("rst_trial", int'(trial), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    rst = 1'b0;
    step();

    run(5, 0);
    run(0, 0);
    run(15, 0);

    // Invalid code on the 2nd test cycle.
    base = ndone;
    launch(5, 2);
    wait_ncyc(3);
    chk("err_mid", int'(err), 1);
    wait_done(base + 1);
    step();
    chk("err_sticky", int'(err), 1);
    fn = 0;

    // Reset on the 3rd test cycle.
    wait_idle();
    unk = 9;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_ncyc(3);
    rst = 1'b1;
    base = ndone;
    step();
    chk("mrst_trial", int'(trial), 0);
    chk("mrst_result", int'(result), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_done", int'(done), 0);
    chk("mrst_err", int'(err), 0);
    rst = 1'b0;
    repeat (3) step();
    chk("mrst_no_done", ndone, base);
    run(9, 0);

    // Start held high: back-to-back searches.
    wait_idle();
    unk = 10;
    fn = 0;
    base = ndone;
    for (int i = 0; i < 3; i++) sb.push_back(model(10, 0));
    start = 1'b1;
    wait_done(base + 3);
    start = 1'b0;
    if (done_cyc.size() >= 3) begin
      int s;
      s = done_cyc.size();
      chk("b2b_period1", done_cyc[s-2] - done_cyc[s-3], W + 2);
      chk("b2b_period2", done_cyc[s-1] - done_cyc[s-2], W + 2);
    end else begin
      chk("b2b_count", done_cyc.size(), 3);
    end

    run(8, 0);

    for (int i = 0; i < 16; i++) begin
      int u, f;
      u = int'($urandom_range(0, 20));
      f = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W)) : 0;
      run(u, f);
    end
    fn = 0;

    repeat (4) step();
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
